// File: rtl/i2c_target_regs.sv
// I2C/SCCB register target: oversamples SCL/SDA, decodes address/pointer/data
// bytes and presents a write strobe plus a pointer-addressed read port.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] sclSync_q, sdaSync_q;
    logic                   sclPrev_q, sdaPrev_q;
    state_e                 state_q, state_d;
    logic [3:0]             bitCnt_q, bitCnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             ptr_q, ptr_d;
    logic                   sdaOe_q, sdaOe_d;
    logic                   wrEn_q, wrEn_d;
    logic [7:0]             wrAddr_q, wrAddr_d;
    logic [7:0]             wrData_q, wrData_d;

    logic sclS, sdaS, sclRise, sclFall, startDet, stopDet, byteDone;
    logic [7:0] sampled;

    assign sclS     = sclSync_q[SYNC_STAGES-1];
    assign sdaS     = sdaSync_q[SYNC_STAGES-1];
    assign sclRise  = sclS & ~sclPrev_q;
    assign sclFall  = ~sclS & sclPrev_q;
    assign startDet = sclS & sclPrev_q & sdaPrev_q & ~sdaS;
    assign stopDet  = sclS & sclPrev_q & ~sdaPrev_q & sdaS;
    assign byteDone = sclFall && (bitCnt_q == 4'd8);
    assign sampled  = {shift_q[6:0], sdaS};

    // Synchronisers reset to the idle-bus level so reset never fakes a START.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclSync_q <= '1;
            sdaSync_q <= '1;
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
            state_q   <= IDLE;
            bitCnt_q  <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= 8'h00;
            sdaOe_q   <= 1'b0;
            wrEn_q    <= 1'b0;
            wrAddr_q  <= 8'h00;
            wrData_q  <= 8'h00;
        end else begin
            sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], scl_in};
            sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], sda_in};
            sclPrev_q <= sclS;
            sdaPrev_q <= sdaS;
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sdaOe_q   <= sdaOe_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        sdaOe_d  = sdaOe_q;
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;

        if (stopDet) begin
            state_d  = IDLE;
            bitCnt_d = 4'd0;
            sdaOe_d  = 1'b0;
        end else if (startDet) begin
            state_d  = ADDR;
            bitCnt_d = 4'd0;
            sdaOe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, WDATA: begin
                    if (sclRise && bitCnt_q != 4'd8) begin
                        shift_d  = sampled;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (state_q == WDATA && bitCnt_q == 4'd7) begin
                            wrEn_d   = 1'b1;
                            wrAddr_d = ptr_q;
                            wrData_d = sampled;
                        end
                    end else if (byteDone) begin
                        bitCnt_d = 4'd0;
                        sdaOe_d  = 1'b1;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                                sdaOe_d = 1'b0;
                            end
                        end else if (state_q == REG) begin
                            ptr_d   = shift_q;
                            state_d = REG_ACK;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            state_d = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (sclFall) begin
                        bitCnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d = RDATA;
                            shift_d = rd_data;
                            sdaOe_d = ~rd_data[7];
                        end else begin
                            state_d = REG;
                            sdaOe_d = 1'b0;
                        end
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (sclFall) begin
                        state_d  = WDATA;
                        bitCnt_d = 4'd0;
                        sdaOe_d  = 1'b0;
                    end
                end
                RDATA: begin
                    if (sclRise && bitCnt_q != 4'd8) begin
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else if (byteDone) begin
                        state_d  = RDATA_ACK;
                        bitCnt_d = 4'd0;
                        sdaOe_d  = 1'b0;
                    end else if (sclFall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sdaOe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    // Pointer moves at the ACK rise so rd_data has settled by the fall.
                    if (sclRise) begin
                        if (sdaS) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end else if (sclFall) begin
                        state_d  = RDATA;
                        bitCnt_d = 4'd0;
                        shift_d  = rd_data;
                        sdaOe_d  = ~rd_data[7];
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe  = sdaOe_q;
    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;
    assign rd_addr = ptr_q;
    assign busy    = (state_q != IDLE);

endmodule
